// File: rtl/pi_mac.sv
// ============================================================================
//  Module   : pi_mac
//  Desc     : Signed PI multiply-accumulate stage. It keeps a saturating
//             integral accumulator and computes P*err + I*acc with a
//             radix-2 shift-add multiplier.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pi_mac #(
    parameter int E_WID      = 18,
    parameter int ACC_WID    = 30,
    parameter int CONSTS_WID = 32,
    parameter int OUT_WID    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [E_WID-1:0]      err,
    input  logic                         err_valid,
    input  logic signed [CONSTS_WID-1:0] cl_p,
    input  logic signed [CONSTS_WID-1:0] cl_i,
    input  logic                         clear_acc,
    output logic signed [OUT_WID-1:0]    sum,
    output logic                         sum_valid,
    output logic                         busy,
    output logic                         acc_sat,
    output logic                         overrun
);

    localparam int PW = CONSTS_WID + ACC_WID;
    localparam int CW = $clog2(ACC_WID + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL_P = 2'd1;
    localparam logic [1:0] S_MUL_I = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_next;
    logic [CW-1:0]            r_cnt;
    logic [PW-1:0]            r_mcand;
    logic [ACC_WID-1:0]       r_mplier;
    logic [PW-1:0]            r_prod;
    logic                     r_neg;
    logic [OUT_WID-1:0]       r_pterm;
    logic [CONSTS_WID-1:0]    r_imag;
    logic                     r_isgn;
    logic [ACC_WID-1:0]       r_acc;
    logic [OUT_WID-1:0]       r_sum;
    logic                     r_acc_sat;
    logic                     r_overrun;

    logic                     w_last_p;
    logic                     w_last_i;
    logic [PW-1:0]            w_prod_next;
    logic [OUT_WID-1:0]       w_mag;
    logic [OUT_WID-1:0]       w_term;
    logic [E_WID-1:0]         w_err_mag;
    logic [CONSTS_WID-1:0]    w_clp_mag;
    logic [CONSTS_WID-1:0]    w_cli_mag;
    logic [ACC_WID-1:0]       w_acc_mag;
    logic [ACC_WID-1:0]       w_acc_base;
    logic [ACC_WID:0]         w_acc_sum;
    logic                     w_ovf;
    logic [ACC_WID-1:0]       w_acc_new;

    // Magnitudes are unsigned, so the most negative operands stay exact.
    assign w_err_mag = err[E_WID-1]         ? -err  : err;
    assign w_clp_mag = cl_p[CONSTS_WID-1]   ? -cl_p : cl_p;
    assign w_cli_mag = cl_i[CONSTS_WID-1]   ? -cl_i : cl_i;
    assign w_acc_mag = r_acc[ACC_WID-1]     ? -r_acc : r_acc;

    assign w_acc_base = clear_acc ? '0 : r_acc;
    assign w_acc_sum  = {w_acc_base[ACC_WID-1], w_acc_base}
                      + {{(ACC_WID+1-E_WID){err[E_WID-1]}}, err};
    assign w_ovf      = w_acc_sum[ACC_WID] ^ w_acc_sum[ACC_WID-1];
    assign w_acc_new  = !w_ovf             ? w_acc_sum[ACC_WID-1:0] :
                        w_acc_sum[ACC_WID] ? {1'b1, {(ACC_WID-1){1'b0}}} :
                                             {1'b0, {(ACC_WID-1){1'b1}}};

    assign w_last_p    = (r_state == S_MUL_P) && (r_cnt == CW'(E_WID - 1));
    assign w_last_i    = (r_state == S_MUL_I) && (r_cnt == CW'(ACC_WID - 1));
    assign w_prod_next = r_mplier[0] ? r_prod + r_mcand : r_prod;
    assign w_mag       = OUT_WID'(w_prod_next);
    assign w_term      = r_neg ? -w_mag : w_mag;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (err_valid) w_next = S_MUL_P;
            S_MUL_P: if (w_last_p)  w_next = S_MUL_I;
            S_MUL_I: if (w_last_i)  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        sum_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_neg     <= 1'b0;
            r_pterm   <= '0;
            r_imag    <= '0;
            r_isgn    <= 1'b0;
            r_acc     <= '0;
            r_sum     <= '0;
            r_acc_sat <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_acc) begin
                        r_acc     <= '0;
                        r_acc_sat <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                    if (err_valid) begin
                        r_acc    <= w_acc_new;
                        if (w_ovf) r_acc_sat <= 1'b1;
                        r_mplier <= ACC_WID'(w_err_mag);
                        r_mcand  <= PW'(w_clp_mag);
                        r_prod   <= '0;
                        r_neg    <= err[E_WID-1] ^ cl_p[CONSTS_WID-1];
                        r_imag   <= w_cli_mag;
                        r_isgn   <= cl_i[CONSTS_WID-1];
                        r_cnt    <= '0;
                    end
                end
                S_MUL_P, S_MUL_I: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last_p) begin
                        // Reload for the integral term; acc already holds this sample.
                        r_pterm  <= w_term;
                        r_mplier <= w_acc_mag;
                        r_mcand  <= PW'(r_imag);
                        r_prod   <= '0;
                        r_neg    <= r_acc[ACC_WID-1] ^ r_isgn;
                        r_cnt    <= '0;
                    end
                    if (w_last_i) r_sum <= r_pterm + w_term;
                    if (err_valid) r_overrun <= 1'b1;
                end
                default: begin
                    if (err_valid) r_overrun <= 1'b1;
                end
            endcase
        end
    end

    assign sum     = r_sum;
    assign acc_sat = r_acc_sat;
    assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: doc/pi_mac.md
Name: pi_mac

Overview:
- Sequential signed multiply-accumulate stage of the control loop, directly upstream of the 64-to-32-bit saturating truncation stage.
- Each accepted error sample is added into a saturating integral accumulator.
- The block then computes P*err + I*acc using a radix-2 shift-add multiplier.
- The result is presented as a 64-bit signed word for saturation down to the DAC/loop width.

Parameters:
- E_WID, 18: signed error sample width.
- ACC_WID, 30: signed integral accumulator width. Must satisfy E_WID <= ACC_WID.
- CONSTS_WID, 32: signed P and I coefficient width.
- OUT_WID, 64: signed output width. Must satisfy CONSTS_WID+ACC_WID+1 <= OUT_WID.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: reset. Synchronous, active-high.
- err, input, E_WID: signed error sample.
- err_valid, input, 1: err is valid this cycle.
- cl_p, input, CONSTS_WID: signed proportional coefficient, latched on accept.
- cl_i, input, CONSTS_WID: signed integral coefficient, latched on accept.
- clear_acc, input, 1: zero the integral accumulator.
- sum, output, OUT_WID: signed P*err + I*acc, fed to the saturation stage.
- sum_valid, output, 1: one-cycle strobe marking a new sum.
- busy, output, 1: computation in progress.
- acc_sat, output, 1: sticky flag; the accumulator has saturated.
- overrun, output, 1: sticky flag; a sample arrived while busy and was dropped.

Behaviour:
- Reset:
  - Any edge with rst=1 forces all outputs to 0: sum, sum_valid, busy, acc_sat, overrun.
  - It also forces acc=0 and state IDLE.
  - Reset aborts any computation in progress; no sum_valid is produced for the aborted sample.
- States: IDLE, MUL_P, MUL_I, DONE.
- IDLE, accept edge (err_valid=1):
  - Latch err, cl_p and cl_i.
  - Set acc <= sat(acc + err).
  - busy <= 1; go to MUL_P.
- IDLE, clear_acc:
  - With clear_acc=1 and err_valid=0, the edge sets acc <= 0.
  - With clear_acc=1 and err_valid=1, clear takes priority, then the add: acc <= err.
  - clear_acc also clears acc_sat and overrun.
  - clear_acc is ignored while busy.
- Saturating add:
  - Compute the sum at ACC_WID+1 bits.
  - Clamp to [-2^(ACC_WID-1), 2^(ACC_WID-1)-1].
  - If clamping occurred, set acc_sat.
- Multiplication method:
  - Multiply magnitudes (unsigned), then negate if the operand signs differ.
  - The most negative operands must give exact results: 2^(E_WID-1) and 2^(CONSTS_WID-1) fit as unsigned magnitudes.
- MUL_P:
  - Exactly E_WID cycles, one multiplier bit of |err| per cycle.
  - Yields P*err at CONSTS_WID+E_WID bits, sign-extended to OUT_WID.
- MUL_I:
  - Exactly ACC_WID cycles over |acc|, using the updated acc value.
  - Yields I*acc at CONSTS_WID+ACC_WID bits, sign-extended.
- DONE:
  - Exactly 1 cycle.
  - sum <= P*err + I*acc at OUT_WID bits; no overflow is possible given the width constraint.
  - sum_valid=1 for this cycle only.
  - Next edge: busy <= 0, state returns to IDLE.
- Latency:
  - sum_valid is high during cycle E_WID+ACC_WID+1 after the accepting edge (49 cycles at defaults).
  - busy is high from the accepting edge through the DONE cycle.
  - A new sample may be accepted on the edge that ends DONE is not allowed. IDLE must be reached first, giving a minimum sample spacing of E_WID+ACC_WID+2 cycles.
- Overrun:
  - err_valid=1 while busy: the sample is dropped and overrun <= 1.
  - acc, state and the latched operands are unaffected.
- Output hold:
  - sum holds its value between DONE cycles.
  - Coefficient changes mid-computation have no effect until the next accept.

Test Plan:
1. Basic MAC: rst, then cl_p=2, cl_i=3, err=100 -> sum=500 (acc=100), sum_valid is a single pulse 49 cycles after accept, busy falls one cycle later.
2. Signed accumulation, continuing from 1: cl_p=-5, cl_i=1, err=-7 -> acc=93, sum=35+93=128. Next sample err=-200 with the same coefficients -> acc=-107, sum=1000-107=893.
3. Extremes: cl_p=-2^31, err=-131072, cl_i=0 -> sum=281474976710656 exactly. Then cl_p=2^31-1, err=131071 from a cleared acc -> P term 281472829095937.
4. Accumulator saturation: cl_i=1, cl_p=0, err=131071 repeated 4097 times -> acc clamps at 536870911 with acc_sat=1. One more sample -> acc stays 536870911. clear_acc with err=5 -> acc=5, acc_sat=0.
5. Overrun: err_valid pulsed 10 cycles after accept -> overrun=1, sum matches the first sample only, acc excludes the dropped value. clear_acc in IDLE -> overrun=0.
6. Reset mid-operation: rst asserted in cycle 20 of MUL_I -> next cycle busy=0, sum=0, acc=0, and no sum_valid follows. A fresh sample then completes normally in 49 cycles.
